lav_arbiter: RTL

- Sequential arbiter that shares three aircraft lavatories between female and male passengers.
- Lavatory 0 is female-only. Lavatories 1 and 2 are unisex.
- Accepts request pulses from two gender queues, grants free lavatories round-robin between genders, tracks occupancy per lavatory and flags overstay.
- Instantiated under top; request and release inputs come from SWI, status drives LED/SEG.

---
 rtl/lav_pkg.sv | 27 ++
 rtl/lav_arbiter_if.sv | 37 +++
 rtl/lav_slot.sv | 70 +++++++
 rtl/lav_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/lav_pkg.sv
// Shared types and constants for the lavatory arbiter: slot states, genders,
// and a lowest-free-slot picker used by the arbitration logic.
package lav_pkg;

    localparam int N_LAV           = 3;
    localparam int FEMALE_ONLY_LAV = 0;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        OCCUPIED = 2'd1,
        OVERTIME = 2'd2
    } lav_state_t;

    typedef enum logic {
        F = 1'b0,
        M = 1'b1
    } gender_t;

    // Index of the lowest set bit; returns 0 for an empty mask (caller gates on eligibility).
    function automatic logic [1:0] lowest_free(input logic [N_LAV-1:0] mask);
        lowest_free = 2'd0;
        for (int i = N_LAV - 1; i >= 0; i--) begin
            if (mask[i]) lowest_free = i[1:0];
        end
    endfunction

endpackage

// File: rtl/lav_arbiter_if.sv
// Request/grant/status bundle between the switch/LED shell and the lavatory arbiter.
interface lav_arbiter_if #(
    parameter int MAX_WAIT = 7
);
    import lav_pkg::*;

    localparam int WW = $clog2(MAX_WAIT + 1);

    // Pulse semantics, no backpressure: req_f/req_m/rel are single-cycle pulses
    // counted once per high cycle; grant_valid and overflow are single-cycle
    // registered pulses; everything else is level status from registers.
    logic                   req_f;
    logic                   req_m;
    logic [N_LAV-1:0]       rel;
    logic                   grant_valid;
    logic [1:0]             grant_lav;
    logic                   grant_gender;
    logic [N_LAV-1:0]       occupied;
    logic [N_LAV-1:0]       alarm;
    logic [WW-1:0]          wait_f;
    logic [WW-1:0]          wait_m;
    logic                   overflow;
    logic [2*N_LAV-1:0]     slot_state;

    modport master (
        output req_f, req_m, rel,
        input  grant_valid, grant_lav, grant_gender, occupied, alarm,
               wait_f, wait_m, overflow, slot_state
    );

    modport slave (
        input  req_f, req_m, rel,
        output grant_valid, grant_lav, grant_gender, occupied, alarm,
               wait_f, wait_m, overflow, slot_state
    );

endinterface

// File: rtl/lav_slot.sv
// One lavatory: FREE/OCCUPIED/OVERTIME state machine with an occupancy timer.
module lav_slot
    import lav_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       grant,
    input  logic       rel,
    output logic       occupied,
    output logic       alarm,
    output lav_state_t state
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    lav_state_t     state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= FREE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Timer reaching TIMEOUT-1 makes the alarm rise exactly TIMEOUT edges after the grant.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            FREE: begin
                if (grant) begin
                    state_d = OCCUPIED;
                    timer_d = '0;
                end
            end
            OCCUPIED: begin
                if (rel) begin
                    state_d = FREE;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = OVERTIME;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            OVERTIME: begin
                if (rel) begin
                    state_d = FREE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = FREE;
                timer_d = '0;
            end
        endcase
    end

    assign occupied = (state_q != FREE);
    assign alarm    = (state_q == OVERTIME);
    assign state    = state_q;

endmodule

// File: rtl/lav_arbiter.sv
// Shares three lavatories between female and male queues: waiting counters,
// gender round-robin, lowest-index slot choice, and per-slot occupancy FSMs.
module lav_arbiter
    import lav_pkg::*;
#(
    parameter int MAX_WAIT = 7,
    parameter int TIMEOUT  = 16
) (
    input  logic         clk_2,
    input  logic         reset,
    lav_arbiter_if.slave bus
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]    WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [WW-1:0]    WAIT_ONE  = WW'(1);
    localparam logic [N_LAV-1:0] MALE_MASK = ~(N_LAV'(1) << FEMALE_ONLY_LAV);

    logic [WW-1:0]      wait_f_q, wait_f_d;
    logic [WW-1:0]      wait_m_q, wait_m_d;
    gender_t            last_served_q;
    logic               grant_valid_q;
    logic [1:0]         grant_lav_q;
    logic               grant_gender_q;
    logic               overflow_q, overflow_d;

    logic [N_LAV-1:0]   occ, alm, free, slot_grant;
    logic [2*N_LAV-1:0] slot_state_w;
    logic               elig_f, elig_m, win_f, win_m;
    logic [1:0]         lav_sel;

    assign free = ~occ;

    always_comb begin
        elig_f = (wait_f_q != '0) && (free != '0);
        elig_m = (wait_m_q != '0) && ((free & MALE_MASK) != '0);
        win_f  = 1'b0;
        win_m  = 1'b0;
        if (elig_f && elig_m) begin
            if (last_served_q == M) win_f = 1'b1;
            else                    win_m = 1'b1;
        end else begin
            win_f = elig_f;
            win_m = elig_m;
        end
        lav_sel = win_m ? lowest_free(free & MALE_MASK) : lowest_free(free);
        for (int i = 0; i < N_LAV; i++) begin
            slot_grant[i] = (win_f || win_m) && (lav_sel == i[1:0]);
        end
    end

    // A same-cycle grant frees a place, so a request at saturation is only dropped without one.
    always_comb begin
        wait_f_d   = wait_f_q;
        wait_m_d   = wait_m_q;
        overflow_d = 1'b0;
        if (bus.req_f && !win_f) begin
            if (wait_f_q == WAIT_MAX) overflow_d = 1'b1;
            else                      wait_f_d   = wait_f_q + WAIT_ONE;
        end else if (!bus.req_f && win_f) begin
            wait_f_d = wait_f_q - WAIT_ONE;
        end
        if (bus.req_m && !win_m) begin
            if (wait_m_q == WAIT_MAX) overflow_d = 1'b1;
            else                      wait_m_d   = wait_m_q + WAIT_ONE;
        end else if (!bus.req_m && win_m) begin
            wait_m_d = wait_m_q - WAIT_ONE;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            wait_f_q       <= '0;
            wait_m_q       <= '0;
            last_served_q  <= M;
            grant_valid_q  <= 1'b0;
            grant_lav_q    <= 2'd0;
            grant_gender_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wait_f_q       <= wait_f_d;
            wait_m_q       <= wait_m_d;
            grant_valid_q  <= win_f || win_m;
            grant_lav_q    <= (win_f || win_m) ? lav_sel : 2'd0;
            grant_gender_q <= win_m;
            overflow_q     <= overflow_d;
            if (win_f)      last_served_q <= F;
            else if (win_m) last_served_q <= M;
        end
    end

    for (genvar i = 0; i < N_LAV; i++) begin : g_slot
        lav_state_t st;
        lav_slot #(.TIMEOUT(TIMEOUT)) u_slot (
            .clk_2    (clk_2),
            .reset    (reset),
            .grant    (slot_grant[i]),
            .rel      (bus.rel[i]),
            .occupied (occ[i]),
            .alarm    (alm[i]),
            .state    (st)
        );
        assign slot_state_w[2*i +: 2] = st;
    end

    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_lav    = grant_lav_q;
    assign bus.grant_gender = grant_gender_q;
    assign bus.occupied     = occ;
    assign bus.alarm        = alm;
    assign bus.wait_f       = wait_f_q;
    assign bus.wait_m       = wait_m_q;
    assign bus.overflow     = overflow_q;
    assign bus.slot_state   = slot_state_w;

endmodule
